// File: rtl/bpi_flash_responder.sv
// Device-side model of a one-block BPI parallel-NOR flash: command interface, status register,
// ID read, and timed word program and block erase.
module bpi_flash_responder #(
    parameter int unsigned AW       = 8,
    parameter int unsigned RD_LAT   = 3,
    parameter int unsigned PROG_CYC = 8,
    parameter logic [15:0] MFR_ID   = 16'h0089,
    parameter logic [15:0] DEV_ID   = 16'h8962
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          E,
    input  logic          G,
    input  logic          L,
    input  logic          W,
    input  logic [AW-1:0] ADDR,
    input  logic [15:0]   DQ_IN,
    output logic [15:0]   DQ_OUT,
    output logic          DQ_OE,
    output logic          BUSY
);
    typedef enum logic [2:0] {
        S_ARRAY, S_STATUS, S_ID, S_PSETUP, S_ESETUP, S_PBUSY, S_EBUSY
    } state_t;

    localparam int unsigned DEPTH  = 1 << AW;
    localparam logic [3:0]  LAT    = 4'(RD_LAT);
    localparam logic [3:0]  LAT_M1 = 4'(RD_LAT - 1);
    localparam logic [7:0]  PCYC   = 8'(PROG_CYC);

    state_t        state, state_n;
    logic [15:0]   mem [DEPTH] = '{default: 16'hFFFF};
    logic [AW-1:0] addr_q, addr_eff;
    logic          w_q, wr, rd;
    logic [7:0]    cmd;
    logic          sr7, sr5, sr4, sr7_n, sr5_n, sr4_n;
    logic [15:0]   sr;
    logic [7:0]    cnt, cnt_n;
    logic [AW-1:0] ecnt, ecnt_n;
    logic [3:0]    rd_cnt;
    logic [15:0]   prog_word, rd_data;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [15:0]   mem_wd;

    assign wr        = E & W & ~w_q;
    assign rd        = E & G & ~(W | wr);
    assign cmd       = DQ_IN[7:0];
    assign addr_eff  = (E && L) ? ADDR : addr_q;
    assign prog_word = mem[addr_eff] & DQ_IN;
    assign sr        = {8'h00, sr7, 1'b0, sr5, sr4, 4'h0};
    assign BUSY      = ~sr7;

    always_comb begin
        rd_data = sr;
        case (state)
            S_ARRAY: rd_data = mem[addr_q];
            S_ID:    rd_data = addr_q[0] ? DEV_ID : MFR_ID;
            default: rd_data = sr;
        endcase
    end

    always_comb begin
        state_n = state;
        sr7_n   = sr7;
        sr5_n   = sr5;
        sr4_n   = sr4;
        cnt_n   = cnt;
        ecnt_n  = ecnt;
        mem_we  = 1'b0;
        mem_wa  = addr_eff;
        mem_wd  = prog_word;
        case (state)
            S_ARRAY, S_STATUS, S_ID: begin
                if (wr) begin
                    case (cmd)
                        8'hFF:        state_n = S_ARRAY;
                        8'h70:        state_n = S_STATUS;
                        8'h90:        state_n = S_ID;
                        8'h50: begin
                            sr5_n = 1'b0;
                            sr4_n = 1'b0;
                        end
                        8'h40, 8'h10: state_n = S_PSETUP;
                        8'h20:        state_n = S_ESETUP;
                        default:      state_n = state;
                    endcase
                end
            end
            S_PSETUP: begin
                if (wr) begin
                    mem_we  = 1'b1;
                    sr4_n   = sr4 | (prog_word != DQ_IN);
                    sr7_n   = 1'b0;
                    cnt_n   = PCYC;
                    state_n = S_PBUSY;
                end
            end
            S_ESETUP: begin
                if (wr) begin
                    if (cmd == 8'hD0) begin
                        sr7_n   = 1'b0;
                        ecnt_n  = '0;
                        state_n = S_EBUSY;
                    end else begin
                        sr5_n   = 1'b1;
                        sr4_n   = 1'b1;
                        state_n = S_STATUS;
                    end
                end
            end
            S_PBUSY: begin
                if (cnt == 8'd1) begin
                    sr7_n   = 1'b1;
                    state_n = S_STATUS;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_EBUSY: begin
                // one word per cycle; the last word is the all-ones address
                mem_we = 1'b1;
                mem_wa = ecnt;
                mem_wd = '1;
                ecnt_n = ecnt + 1'b1;
                if (&ecnt) begin
                    sr7_n   = 1'b1;
                    state_n = S_STATUS;
                end
            end
            default: state_n = S_ARRAY;
        endcase
    end

    // Array is non-volatile: never reset, but a reset cycle suppresses any pending write.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_ARRAY;
            sr7    <= 1'b1;
            sr5    <= 1'b0;
            sr4    <= 1'b0;
            cnt    <= '0;
            ecnt   <= '0;
            addr_q <= '0;
            w_q    <= 1'b0;
            rd_cnt <= '0;
            DQ_OUT <= '0;
            DQ_OE  <= 1'b0;
        end else begin
            state <= state_n;
            sr7   <= sr7_n;
            sr5   <= sr5_n;
            sr4   <= sr4_n;
            cnt   <= cnt_n;
            ecnt  <= ecnt_n;
            w_q   <= W;
            if (E && L) addr_q <= ADDR;
            DQ_OE <= rd;
            if (rd) begin
                if (rd_cnt < LAT) rd_cnt <= rd_cnt + 4'd1;
                DQ_OUT <= (rd_cnt < LAT_M1) ? '0 : rd_data;
            end else begin
                rd_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bpi_flash_responder.sv
// Scoreboard bench for bpi_flash_responder: reads push expected words, a negedge monitor
// compares DQ_OUT on the RD_LAT-th consecutive DQ_OE cycle.
module tb_bpi_flash_responder;
    localparam int unsigned AW       = 8;
    localparam int unsigned RD_LAT   = 3;
    localparam int unsigned PROG_CYC = 8;

    logic          CLK = 1'b0;
    logic          RST, E, G, L, W;
    logic [AW-1:0] ADDR;
    logic [15:0]   DQ_IN, DQ_OUT;
    logic          DQ_OE, BUSY;

    int total = 0;
    int bad   = 0;
    int oe_run = 0;
    int busy_total = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];

    bpi_flash_responder #(
        .AW(AW), .RD_LAT(RD_LAT), .PROG_CYC(PROG_CYC),
        .MFR_ID(16'h0089), .DEV_ID(16'h8962)
    ) dut (
        .CLK(CLK), .RST(RST), .E(E), .G(G), .L(L), .W(W),
        .ADDR(ADDR), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    always @(negedge CLK) begin
        if (BUSY === 1'b1) busy_total++;
        if (RST || DQ_OE !== 1'b1) begin
            oe_run = 0;
        end else begin
            oe_run++;
            if (oe_run == RD_LAT) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %h required no read", DQ_OUT);
                end else begin
                    check(name_q.pop_front(), DQ_OUT, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d, input logic latch);
        E = 1'b1; W = 1'b1; L = latch; ADDR = a; DQ_IN = d;
        cyc();
        E = 1'b0; W = 1'b0; L = 1'b0;
        cyc();
    endtask

    task automatic latch_addr(input logic [AW-1:0] a);
        E = 1'b1; L = 1'b1; ADDR = a;
        cyc();
        E = 1'b0; L = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [15:0] exp, input int hold);
        exp_q.push_back(exp);
        name_q.push_back(name);
        E = 1'b1; G = 1'b1;
        repeat (hold) cyc();
        E = 1'b0; G = 1'b0;
        cyc();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000 && BUSY === 1'b1; i++) cyc();
        cyc();
        check(name, 16'(BUSY), 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        RST = 1'b1; E = 1'b0; G = 1'b0; L = 1'b0; W = 1'b0; ADDR = '0; DQ_IN = '0;
        cyc(); cyc();
        RST = 1'b0;
        check("reset_dq_out", DQ_OUT, 16'h0000);
        check("reset_dq_oe", 16'(DQ_OE), 16'h0000);
        check("reset_busy", 16'(BUSY), 16'h0000);

        // 1: erased array read with latency
        latch_addr(8'd5);
        E = 1'b1; G = 1'b1;
        cyc();
        check("t1_oe_cycle1", 16'(DQ_OE), 16'h0001);
        check("t1_out_cycle1", DQ_OUT, 16'h0000);
        E = 1'b0; G = 1'b0;
        cyc();
        bus_read("t1_read5", 16'hFFFF, 4);

        // 2: program 1234 at 7
        bus_write(8'd0, 16'h0040, 1'b0);
        b0 = busy_total;
        bus_write(8'd7, 16'h1234, 1'b1);
        wait_idle("t2_idle");
        check("t2_busy_cycles", 16'(busy_total - b0), 16'd8);
        bus_read("t2_status", 16'h0080, RD_LAT);
        bus_write(8'd0, 16'h00FF, 1'b0);
        bus_read("t2_read7", 16'h1234, RD_LAT);

        // 3: program over existing data -> bits only clear, SR4 flags the mismatch
        bus_write(8'd0, 16'h0010, 1'b0);
        bus_write(8'd7, 16'h00FF, 1'b1);
        wait_idle("t3_idle");
        bus_read("t3_status", 16'h0090, RD_LAT);
        bus_write(8'd0, 16'h00FF, 1'b0);
        bus_read("t3_read7", 16'h0034, RD_LAT);
        bus_write(8'd0, 16'h0050, 1'b0);
        bus_write(8'd0, 16'h0070, 1'b0);
        bus_read("t3_cleared", 16'h0080, RD_LAT);

        // 4: full erase
        bus_write(8'd0, 16'h0020, 1'b0);
        b0 = busy_total;
        bus_write(8'd0, 16'h00D0, 1'b0);
        bus_read("t4_mid_erase", 16'h0000, RD_LAT);
        wait_idle("t4_idle");
        check("t4_busy_cycles", 16'(busy_total - b0), 16'd256);
        bus_read("t4_status", 16'h0080, RD_LAT);
        bus_write(8'd0, 16'h00FF, 1'b0);
        latch_addr(8'd7);
        bus_read("t4_read7", 16'hFFFF, RD_LAT);

        // 5: bad erase confirm, then ID reads
        bus_write(8'd0, 16'h0020, 1'b0);
        bus_write(8'd0, 16'h0055, 1'b0);
        check("t5_not_busy", 16'(BUSY), 16'h0000);
        bus_read("t5_status", 16'h00B0, RD_LAT);
        bus_write(8'd0, 16'h0090, 1'b0);
        latch_addr(8'd0);
        bus_read("t5_mfr", 16'h0089, RD_LAT);
        latch_addr(8'd1);
        bus_read("t5_dev", 16'h8962, RD_LAT);
        latch_addr(8'hFE);
        bus_read("t5_mfr_hi", 16'h0089, RD_LAT);
        latch_addr(8'hFF);
        bus_read("t5_dev_hi", 16'h8962, RD_LAT);
        bus_write(8'd0, 16'h0050, 1'b0);
        bus_write(8'd0, 16'h00FF, 1'b0);

        // 6: reset during erase cycle 100
        bus_write(8'd0, 16'h0040, 1'b0);
        bus_write(8'd98, 16'h1111, 1'b1);
        wait_idle("t6_idle98");
        bus_write(8'd0, 16'h0040, 1'b0);
        bus_write(8'd100, 16'hABCD, 1'b1);
        wait_idle("t6_idle100");
        bus_write(8'd0, 16'h0040, 1'b0);
        bus_write(8'd200, 16'h0F0F, 1'b1);
        wait_idle("t6_idle200");
        bus_write(8'd0, 16'h0070, 1'b0);
        bus_read("t6_pre_status", 16'h0080, RD_LAT);
        bus_write(8'd0, 16'h0020, 1'b0);
        E = 1'b1; W = 1'b1; DQ_IN = 16'h00D0;
        cyc();
        E = 1'b0; W = 1'b0;
        repeat (99) cyc();
        check("t6_busy_before_rst", 16'(BUSY), 16'h0001);
        RST = 1'b1;
        cyc();
        check("t6_busy_after_rst", 16'(BUSY), 16'h0000);
        RST = 1'b0;
        cyc();
        bus_write(8'd0, 16'h0070, 1'b0);
        bus_read("t6_status", 16'h0080, RD_LAT);
        bus_write(8'd0, 16'h00FF, 1'b0);
        latch_addr(8'd0);
        bus_read("t6_mem0", 16'hFFFF, RD_LAT);
        latch_addr(8'd98);
        bus_read("t6_mem98", 16'hFFFF, RD_LAT);
        latch_addr(8'd100);
        bus_read("t6_mem100", 16'hABCD, RD_LAT);
        latch_addr(8'd200);
        bus_read("t6_mem200", 16'h0F0F, RD_LAT);

        repeat (4) cyc();
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
